// File: rtl/rr_arbiter_8x3.sv
// Round-robin arbiter for 8 requesters with registered one-hot grant, encoded
// index, and grant hold/release/timeout handling.
module rr_arbiter_8x3 #(
  parameter int N_REQ    = 8,
  parameter int IDX_W    = 3,
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             timeout
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t             state_r, state_s;
  logic [IDX_W-1:0]   ptr_r, ptr_s;
  logic [CNT_W-1:0]   hold_cnt_r, hold_cnt_s;
  logic [N_REQ-1:0]   gnt_s;
  logic [IDX_W-1:0]   gnt_idx_s;
  logic               gnt_valid_s;
  logic               timeout_s;
  logic [2*N_REQ-1:0] dbl_s;
  logic [N_REQ-1:0]   rot_s;
  logic [IDX_W-1:0]   off_s;
  logic [IDX_W-1:0]   win_s;
  logic               at_limit_s;
  logic               owner_req_s;
  logic               release_s;

  // Same 8-to-3 encoding as the lab encoder: index of the set bit, 0 if none.
  function automatic logic [IDX_W-1:0] enc8to3(input logic [N_REQ-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = {IDX_W{1'b0}};
    for (int i = 0; i < N_REQ; i++) begin
      if (oh[i]) begin
        idx = IDX_W'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  function automatic logic [N_REQ-1:0] dec3to8(input logic [IDX_W-1:0] idx);
    return {{(N_REQ-1){1'b0}}, 1'b1} << idx;
  endfunction

  // Rotate requests so bit 0 is the current highest-priority requester, then
  // pick the lowest set bit and rotate the offset back.
  always_comb begin
    dbl_s = {req, req} >> ptr_r;
    rot_s = dbl_s[N_REQ-1:0];
    off_s = {IDX_W{1'b0}};
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot_s[i]) begin
        off_s = IDX_W'(i);
      end else begin
        off_s = off_s;
      end
    end
    win_s = ptr_r + off_s;
  end

  // Release qualification for the current owner.
  always_comb begin
    at_limit_s  = (hold_cnt_r == CNT_W'(MAX_HOLD - 1));
    owner_req_s = req[gnt_idx];
    release_s   = done | ~owner_req_s | at_limit_s;
  end

  // Next-state and next-output logic.
  always_comb begin
    state_s     = state_r;
    ptr_s       = ptr_r;
    hold_cnt_s  = hold_cnt_r;
    gnt_s       = gnt;
    gnt_idx_s   = gnt_idx;
    gnt_valid_s = gnt_valid;
    timeout_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (|req) begin
          state_s     = GRANT;
          gnt_s       = dec3to8(win_s);
          gnt_idx_s   = enc8to3(gnt_s);
          gnt_valid_s = 1'b1;
          hold_cnt_s  = {CNT_W{1'b0}};
        end else begin
          state_s     = IDLE;
          gnt_s       = {N_REQ{1'b0}};
          gnt_idx_s   = {IDX_W{1'b0}};
          gnt_valid_s = 1'b0;
        end
      end
      GRANT: begin
        if (release_s) begin
          state_s     = IDLE;
          gnt_s       = {N_REQ{1'b0}};
          gnt_idx_s   = {IDX_W{1'b0}};
          gnt_valid_s = 1'b0;
          ptr_s       = gnt_idx + {{(IDX_W-1){1'b0}}, 1'b1};
          hold_cnt_s  = {CNT_W{1'b0}};
          // Only a pure hold-limit release counts as a timeout.
          timeout_s   = at_limit_s & ~done & owner_req_s;
        end else begin
          hold_cnt_s  = hold_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_s     = IDLE;
        ptr_s       = {IDX_W{1'b0}};
        hold_cnt_s  = {CNT_W{1'b0}};
        gnt_s       = {N_REQ{1'b0}};
        gnt_idx_s   = {IDX_W{1'b0}};
        gnt_valid_s = 1'b0;
      end
    endcase
  end

  // State, pointer, counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      ptr_r      <= {IDX_W{1'b0}};
      hold_cnt_r <= {CNT_W{1'b0}};
      gnt        <= {N_REQ{1'b0}};
      gnt_idx    <= {IDX_W{1'b0}};
      gnt_valid  <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      state_r    <= state_s;
      ptr_r      <= ptr_s;
      hold_cnt_r <= hold_cnt_s;
      gnt        <= gnt_s;
      gnt_idx    <= gnt_idx_s;
      gnt_valid  <= gnt_valid_s;
      timeout    <= timeout_s;
    end
  end

endmodule

// File: tb/tb_rr_arbiter_8x3.sv
// Bench for rr_arbiter_8x3: directed test plan steps followed by random
// traffic, all checked against a grant-ownership reference model.
module tb_rr_arbiter_8x3;

  localparam int MAX_HOLD = 16;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Reference model: who owns the resource, for how many cycles, and who
  // has priority next.
  int   m_owner = -1;
  int   m_ptr   = 0;
  int   m_held  = 0;
  logic m_to    = 1'b0;

  rr_arbiter_8x3 #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done),
    .gnt(gnt), .gnt_idx(gnt_idx), .gnt_valid(gnt_valid), .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_held  = 0;
    m_to    = 1'b0;
  endtask

  task automatic model_step(input logic [7:0] r, input logic d);
    bit found;
    m_to = 1'b0;
    if (m_owner < 0) begin
      found = 1'b0;
      for (int j = 0; j < 8; j++) begin
        int c;
        c = (m_ptr + j) % 8;
        if (!found && r[c]) begin
          found   = 1'b1;
          m_owner = c;
          m_held  = 1;
        end
      end
    end else if (d || !r[m_owner] || m_held == MAX_HOLD) begin
      m_to    = (m_held == MAX_HOLD) && !d && r[m_owner];
      m_ptr   = (m_owner + 1) % 8;
      m_owner = -1;
      m_held  = 0;
    end else begin
      m_held++;
    end
  endtask

  task automatic model_compare();
    logic [7:0] eg;
    logic [7:0] ei;
    eg = (m_owner < 0) ? 8'h00 : (8'h01 << m_owner);
    ei = (m_owner < 0) ? 8'h00 : 8'(m_owner);
    chk("model_gnt", gnt, eg);
    chk("model_gnt_idx", {5'b0, gnt_idx}, ei);
    chk("model_gnt_valid", {7'b0, gnt_valid}, {7'b0, (m_owner >= 0)});
    chk("model_timeout", {7'b0, timeout}, {7'b0, m_to});
  endtask

  // Drive inputs for one cycle, advance model and DUT, then compare.
  task automatic cyc(input logic [7:0] r, input logic d);
    req  = r;
    done = d;
    model_step(r, d);
    @(posedge clk);
    #1;
    model_compare();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int hi;
    logic [7:0] rr;
    rst_n = 1'b0;
    req   = 8'hFF;
    done  = 1'b0;

    // 1. Reset with all requests asserted.
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_gnt", gnt, 8'h00);
    chk("rst_idx", {5'b0, gnt_idx}, 8'h00);
    chk("rst_valid", {7'b0, gnt_valid}, 8'h00);
    chk("rst_timeout", {7'b0, timeout}, 8'h00);
    rst_n = 1'b1;
    cyc(8'hFF, 1'b0);
    chk("first_gnt", gnt, 8'h01);
    chk("first_idx", {5'b0, gnt_idx}, 8'h00);
    cyc(8'hFF, 1'b1);

    // 2. Single requester 5 with done in its third grant cycle.
    cyc(8'h20, 1'b0);
    chk("single_gnt", gnt, 8'h20);
    chk("single_idx", {5'b0, gnt_idx}, 8'h05);
    chk("single_valid", {7'b0, gnt_valid}, 8'h01);
    cyc(8'h20, 1'b0);
    cyc(8'h20, 1'b0);
    cyc(8'h20, 1'b1);
    chk("single_release", gnt, 8'h00);

    // 3. Round robin through all requesters from a fresh pointer.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      cyc(8'hFF, 1'b0);
      chk("rr_idx", {5'b0, gnt_idx}, 8'(i % 8));
      cyc(8'hFF, 1'b1);
      chk("rr_idle", {7'b0, gnt_valid}, 8'h00);
    end

    // 4. Pointer wrap after requester 6.
    cyc(8'h40, 1'b0);
    cyc(8'h40, 1'b1);
    cyc(8'h41, 1'b0);
    chk("wrap_gnt0", gnt, 8'h01);
    cyc(8'h41, 1'b1);
    cyc(8'h41, 1'b0);
    chk("wrap_gnt6", gnt, 8'h40);
    cyc(8'h41, 1'b1);

    // 5. Hold-limit timeout, then a limit release that coincides with done.
    cyc(8'h08, 1'b0);
    hi = 1;
    for (int k = 0; k < 40; k++) begin
      cyc(8'h08, 1'b0);
      if (gnt == 8'h00) break;
      hi++;
    end
    chk("to_hold_cycles", 8'(hi), 8'(MAX_HOLD));
    chk("to_pulse", {7'b0, timeout}, 8'h01);
    chk("to_gnt_low", gnt, 8'h00);
    cyc(8'h08, 1'b0);
    chk("to_regrant", gnt, 8'h08);
    chk("to_pulse_clear", {7'b0, timeout}, 8'h00);
    for (int k = 0; k < MAX_HOLD - 1; k++) cyc(8'h08, 1'b0);
    chk("to_done_still_held", gnt, 8'h08);
    cyc(8'h08, 1'b1);
    chk("to_done_gnt", gnt, 8'h00);
    chk("to_done_no_pulse", {7'b0, timeout}, 8'h00);

    // 6. Asynchronous reset in the middle of a grant.
    cyc(8'h10, 1'b0);
    chk("mid_gnt", gnt, 8'h10);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("mid_async_gnt", gnt, 8'h00);
    chk("mid_async_valid", {7'b0, gnt_valid}, 8'h00);
    chk("mid_async_timeout", {7'b0, timeout}, 8'h00);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(8'h30, 1'b0);
    chk("mid_regrant", gnt, 8'h10);
    chk("mid_regrant_idx", {5'b0, gnt_idx}, 8'h04);
    cyc(8'h30, 1'b1);

    // Random traffic: sticky request patterns so long holds and timeouts occur.
    rr = 8'h00;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 9) < 2) rr = 8'($urandom_range(0, 255));
      cyc(rr, ($urandom_range(0, 15) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
